// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit_pkg
// Purpose : Shared definitions for the instruction-fetch stage.
//           This file holds the fetch FSM state encoding, the default
//           datapath width, the default reset PC and the canonical NOP word.
// Ports   : none (package)
// Config  : FETCH_MISALIGN_CHECK_EN (consumed by pc_register and top)
// Rev     : 1.0  initial release
// ============================================================================
package instr_fetch_unit_pkg;

    localparam int          c_XLEN     = 32;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_register.sv
`default_nettype none
// ============================================================================
// Module  : pc_register
// Purpose : Program counter for the fetch stage.
//           A load has priority over an increment. Redirect targets are
//           word-aligned here.
// Ports   : clk, reset          clock / async active-high reset
//           i_load, i_load_value redirect strobe and target
//           i_inc                advance PC by 4 (wraps modulo 2^XLEN)
//           o_pc                 current PC
//           o_load_target        aligned (or checked) redirect target
//           o_load_bad           redirect rejected as misaligned
// Config  : FETCH_MISALIGN_CHECK_EN
//             defined   misaligned targets are rejected (o_load_bad=1)
//             undefined low two target bits are forced to zero
// Rev     : 1.0  initial release
// ============================================================================
module pc_register
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = c_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_value,
    input  logic            i_inc,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_load_target,
    output logic            o_load_bad
);

    logic [XLEN-1:0] r_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign o_load_bad    = i_load && (i_load_value[1:0] != 2'b00);
    assign o_load_target = i_load_value;
`else
    assign o_load_bad    = 1'b0;
    assign o_load_target = i_load_value & ~XLEN'(3);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (i_load && !o_load_bad) begin
            r_pc <= o_load_target;
        end else if (i_inc) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Purpose : Instruction-fetch stage that feeds the multicycle control FSM.
//           It owns the PC and runs a req/ack cycle with instruction memory.
//           It holds the returned word for control under valid/ready.
//           It also accepts branch/jump redirects.
// Ports   : clk, reset                  clock / async active-high reset
//           fetch_req                   control asks for the next instruction
//           pc_load, pc_next            redirect strobe and target
//           imem_req, imem_addr         memory request (held until ack)
//           imem_ack, imem_rdata        memory response
//           instr, instr_pc, instr_valid held instruction to control
//           instr_ready                 control consumes the instruction
//           busy                        FSM not idle
//           fetch_fault                 sticky misaligned-redirect fault
// Config  : FETCH_MISALIGN_CHECK_EN (see pc_register); fetch_fault is
//           constant 0 when undefined
// Rev     : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = c_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_next,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            busy,
    output logic            fetch_fault
);

    fetch_state_t    r_state;
    logic            r_imem_req;
    logic [XLEN-1:0] r_addr;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_instr_valid;
    logic            r_busy;
    logic            r_flush_pend;

    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_load_target;
    logic            w_load_bad;
    logic            w_inc;
    logic            w_halt;

    // The PC advances only when a fetch completes and its data is kept.
    // A redirect in the same cycle, or an earlier one, wins instead.
    assign w_inc = (r_state == WAIT) && imem_ack && !r_flush_pend && !pc_load;

    pc_register #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .reset         (reset),
        .i_load        (pc_load),
        .i_load_value  (pc_next),
        .i_inc         (w_inc),
        .o_pc          (w_pc),
        .o_load_target (w_load_target),
        .o_load_bad    (w_load_bad)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_load_bad) begin
            r_fault <= 1'b1;
        end
    end

    assign fetch_fault = r_fault;
`else
    assign fetch_fault = 1'b0;
`endif

    // A fault blocks new requests. This includes a fault raised this cycle.
    assign w_halt = fetch_fault || w_load_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_imem_req    <= 1'b0;
            r_addr        <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_flush_pend  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch_req && !w_halt) begin
                        r_state    <= WAIT;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                        // A simultaneous redirect supplies the address directly.
                        r_addr     <= pc_load ? w_load_target : w_pc;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        r_imem_req <= 1'b0;
                        if (r_flush_pend || pc_load) begin
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                            r_flush_pend <= 1'b0;
                        end else begin
                            r_state       <= HOLD;
                            r_instr       <= imem_rdata;
                            r_instr_pc    <= r_addr;
                            r_instr_valid <= 1'b1;
                        end
                    end else if (pc_load) begin
                        // The bus cycle cannot be aborted. Drop its data when it arrives.
                        r_flush_pend <= 1'b1;
                    end
                end
                HOLD: begin
                    if (pc_load) begin
                        r_state       <= IDLE;
                        r_instr_valid <= 1'b0;
                        r_busy        <= 1'b0;
                    end else if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        if (fetch_req && !w_halt) begin
                            r_state    <= WAIT;
                            r_imem_req <= 1'b1;
                            r_addr     <= w_pc;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_flush_pend  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_addr;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign busy        = r_busy;

endmodule
`default_nettype wire
